// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side load/store responder with programmable
// wait states in front of an internal little-endian byte-addressed RAM.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid / req_ready    request handshake (one outstanding request)
//   req_we, req_size         store enable, access size (byte/half/word/illegal)
//   req_unsigned             load zero-extension select
//   req_addr, req_wdata      byte address, store data
//   resp_valid / resp_ready  response handshake
//   resp_rdata, resp_err     load result (0 for stores/errors), access error
module data_mem_responder #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned WAIT_CYCLES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                     we;
        logic [1:0]               size;
        logic                     is_unsigned;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    wdata;
    } req_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    req_t                    req_q;
    logic                    accept;
    logic                    access;
    logic                    ready_next;
    logic                    valid_next;
    logic [DATA_WIDTH-1:0]   rdata_next;
    logic                    err_next;

    logic [7:0]              mem [DEPTH];

    logic [ADDRESS_WIDTH-1:0] a0, a1, a2, a3;
    logic [7:0]               b0, b1, b2, b3;
    logic                     acc_err;
    logic [DATA_WIDTH-1:0]    load_val;
    logic [DATA_WIDTH-1:0]    acc_rdata;

    // Byte lanes of the latched address; aligned accesses never wrap.
    always_comb begin
        a0 = req_q.addr;
        a1 = ADDRESS_WIDTH'(req_q.addr + ADDRESS_WIDTH'(1));
        a2 = ADDRESS_WIDTH'(req_q.addr + ADDRESS_WIDTH'(2));
        a3 = ADDRESS_WIDTH'(req_q.addr + ADDRESS_WIDTH'(3));
        b0 = mem[a0];
        b1 = mem[a1];
        b2 = mem[a2];
        b3 = mem[a3];
    end

    // Alignment / legality check and extended load value.
    always_comb begin
        acc_err  = 1'b0;
        load_val = '0;
        case (req_q.size)
            SIZE_BYTE: begin
                load_val = {{24{b0[7] & ~req_q.is_unsigned}}, b0};
            end
            SIZE_HALF: begin
                acc_err  = req_q.addr[0];
                load_val = {{16{b1[7] & ~req_q.is_unsigned}}, b1, b0};
            end
            SIZE_WORD: begin
                acc_err  = (req_q.addr[1:0] != 2'b00);
                load_val = {b3, b2, b1, b0};
            end
            default: begin
                acc_err  = 1'b1;
            end
        endcase
        acc_rdata = (acc_err || req_q.we) ? '0 : load_val;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        access     = 1'b0;
        ready_next = req_ready;
        valid_next = resp_valid;
        rdata_next = resp_rdata;
        err_next   = resp_err;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    state_next = S_WAIT;
                    cnt_next   = CNT_W'(WAIT_CYCLES);
                    ready_next = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = S_RESP;
                    valid_next = 1'b1;
                    rdata_next = acc_rdata;
                    err_next   = acc_err;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                    valid_next = 1'b0;
                    ready_next = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
                ready_next = 1'b1;
                valid_next = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            req_ready  <= ready_next;
            resp_valid <= valid_next;
            resp_rdata <= rdata_next;
            resp_err   <= err_next;
        end
    end

    // Request capture on the accept edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.we          <= req_we;
            req_q.size        <= req_size;
            req_q.is_unsigned <= req_unsigned;
            req_q.addr        <= req_addr;
            req_q.wdata       <= req_wdata;
        end
    end

    // RAM write on the access edge only; contents survive reset.
    always_ff @(posedge clk) begin
        if (access && req_q.we && !acc_err) begin
            mem[a0] <= req_q.wdata[7:0];
            if (req_q.size != SIZE_BYTE) begin
                mem[a1] <= req_q.wdata[15:8];
            end
            if (req_q.size == SIZE_WORD) begin
                mem[a2] <= req_q.wdata[23:16];
                mem[a3] <= req_q.wdata[31:24];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: two instances (2 and 0 wait states)
// driven from shared request signals, selected by 'sel'.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        rv2, rv0;
    logic        rdy2, rdy0, vld2, vld0, err2, err0;
    logic [31:0] rd2, rd0;

    logic        cur_ready, cur_valid, cur_err;
    logic [31:0] cur_rdata;

    int errors = 0;
    int checks = 0;

    assign rv2       = req_valid & ~sel;
    assign rv0       = req_valid & sel;
    assign cur_ready = sel ? rdy0 : rdy2;
    assign cur_valid = sel ? vld0 : vld2;
    assign cur_err   = sel ? err0 : err2;
    assign cur_rdata = sel ? rd0 : rd2;

    data_mem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(rv2), .req_ready(rdy2),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(vld2), .resp_ready(resp_ready),
        .resp_rdata(rd2), .resp_err(err2)
    );

    data_mem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(rv0), .req_ready(rdy0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(vld0), .resp_ready(resp_ready),
        .resp_rdata(rd0), .resp_err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic we, input logic [1:0] size,
                                input logic uns, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err);
        vec_t v;
        v.sel = s; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request (called at a negedge), wait for resp_valid.
    // Returns the number of rising edges from accept to resp_valid.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         output int lat, output logic ok);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 8'hFF;
        req_wdata = 32'h0BAD_0BAD;
        lat = 0;
        ok  = 1'b1;
        while (!cur_valid) begin
            if (lat >= 20) begin
                ok = 1'b0;
                checks++;
                errors++;
                $display("FAIL timeout: got no resp_valid after %0d cycles expected response", lat);
                break;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    // Complete a response with resp_ready high and check the return to idle.
    task automatic finish_resp(input string name);
        @(posedge clk);
        @(negedge clk);
        chk({name, " valid_drop"}, 32'(cur_valid), 32'd0);
        chk({name, " ready_back"}, 32'(cur_ready), 32'd1);
    endtask

    task automatic run(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int   lat;
        logic ok;
        issue(we, size, uns, addr, wdata, lat, ok);
        if (ok) begin
            chk({name, " rdata"}, cur_rdata, exp_rdata);
            chk({name, " err"}, 32'(cur_err), 32'(exp_err));
            chk({name, " latency"}, 32'(lat), sel ? 32'd1 : 32'd3);
            finish_resp(name);
        end
    endtask

    initial begin
        int          lat;
        logic        ok;
        logic [31:0] held;

        rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst req_ready", 32'(cur_ready), 32'd1);
        chk("rst resp_valid", 32'(cur_valid), 32'd0);
        chk("rst resp_rdata", cur_rdata, 32'd0);
        chk("rst resp_err", 32'(cur_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Reset in the middle of a store's wait states discards the store.
        run("pre_store", 1'b1, 2'b10, 1'b0, 8'h10, 32'hCAFE_F00D, 32'h0, 1'b0);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 8'h10; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("in_wait req_ready", 32'(cur_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst req_ready", 32'(cur_ready), 32'd1);
        chk("midrst resp_valid", 32'(cur_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst resp_valid", 32'(cur_valid), 32'd0);
        run("load_after_rst", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Directed vectors: {sel, we, size, uns, addr, wdata, exp_rdata, exp_err}.
        vecs.push_back(mk(0, 1, 2'b10, 0, 8'h20, 32'h1234_5678, 32'h0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h21, 32'h0, 32'h0000_0056, 0));
        vecs.push_back(mk(0, 0, 2'b01, 0, 8'h22, 32'h0, 32'h0000_1234, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h23, 32'h0, 32'h0000_0012, 0));
        vecs.push_back(mk(0, 0, 2'b10, 1, 8'h20, 32'h0, 32'h1234_5678, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 8'h30, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 2'b00, 0, 8'h30, 32'hFFFF_FF80, 32'h0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h30, 32'h0, 32'hFFFF_FF80, 0));
        vecs.push_back(mk(0, 0, 2'b00, 1, 8'h30, 32'h0, 32'h0000_0080, 0));
        vecs.push_back(mk(0, 1, 2'b01, 0, 8'h32, 32'h1234_FFFF, 32'h0, 0));
        vecs.push_back(mk(0, 0, 2'b10, 0, 8'h30, 32'h0, 32'hFFFF_0080, 0));
        vecs.push_back(mk(0, 0, 2'b01, 0, 8'h32, 32'h0, 32'hFFFF_FFFF, 0));
        vecs.push_back(mk(0, 0, 2'b01, 1, 8'h32, 32'h0, 32'h0000_FFFF, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 8'h04, 32'h1122_3344, 32'h0, 0));
        vecs.push_back(mk(0, 0, 2'b10, 0, 8'h05, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 2'b01, 0, 8'h07, 32'hAAAA_AAAA, 32'h0, 1));
        vecs.push_back(mk(0, 0, 2'b11, 0, 8'h08, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 2'b10, 0, 8'h04, 32'h0, 32'h1122_3344, 0));
        vecs.push_back(mk(0, 0, 2'b01, 0, 8'h06, 32'h0, 32'h0000_1122, 0));
        // Zero-wait instance, back-to-back.
        vecs.push_back(mk(1, 1, 2'b10, 0, 8'h40, 32'hA5A5_0001, 32'h0, 0));
        vecs.push_back(mk(1, 0, 2'b10, 0, 8'h40, 32'h0, 32'hA5A5_0001, 0));
        vecs.push_back(mk(1, 1, 2'b00, 0, 8'h41, 32'h0000_007F, 32'h0, 0));
        vecs.push_back(mk(1, 0, 2'b01, 0, 8'h40, 32'h0, 32'h0000_7F01, 0));
        vecs.push_back(mk(1, 0, 2'b10, 0, 8'h40, 32'h0, 32'hA5A5_7F01, 0));
        vecs.push_back(mk(1, 0, 2'b01, 0, 8'h42, 32'h0, 32'hFFFF_A5A5, 0));
        vecs.push_back(mk(1, 0, 2'b01, 0, 8'h43, 32'h0, 32'h0, 1));

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            run($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].uns,
                vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Backpressure: response held while resp_ready is low.
        sel = 1'b0;
        resp_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, lat, ok);
        if (ok) begin
            held = cur_rdata;
            chk("bp rdata", held, 32'h1234_5678);
            for (int k = 0; k < 5; k++) begin
                req_addr = 8'(k * 7);
                req_size = 2'(k);
                @(posedge clk);
                @(negedge clk);
                chk($sformatf("bp%0d valid", k), 32'(cur_valid), 32'd1);
                chk($sformatf("bp%0d rdata", k), cur_rdata, held);
                chk($sformatf("bp%0d req_ready", k), 32'(cur_ready), 32'd0);
            end
            resp_ready = 1'b1;
            finish_resp("bp_release");
        end
        resp_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the CPU's load/store port. It accepts one request at a time over a valid/ready channel and inserts a programmable number of wait states. It then performs a little-endian byte, halfword or word access on an internal byte-addressed RAM and returns read data over a second valid/ready channel. The block sits opposite the core's memory-access initiator and replaces the zero-latency data memory, so stall handling in the datapath can be exercised.

Parameters:
DATA_WIDTH, 32, width of write and read data; fixed at 32 for this core.
ADDRESS_WIDTH, 8, byte-address width; the RAM holds 2**ADDRESS_WIDTH bytes.
WAIT_CYCLES, 2, wait states between request accept and response; legal range 0..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
req_valid  input  1  initiator presents a request.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  input  ADDRESS_WIDTH  byte address.
req_wdata  input  DATA_WIDTH  store data; low bytes are used for byte and half stores.
resp_valid  output  1  response available.
resp_ready  input  1  initiator accepts the response.
resp_rdata  output  DATA_WIDTH  load result; 0 for stores and errors.
resp_err  output  1  access was misaligned or illegal.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
  - RAM contents are not cleared.
  - If reset arrives in WAIT, the pending store is discarded and RAM is unchanged.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid && req_ready at a rising edge, latch we, size, unsigned, addr and wdata. Go to WAIT with counter = WAIT_CYCLES, or go straight to the access step if WAIT_CYCLES = 0.
  - WAIT: req_ready = 0. Decrement the counter each cycle. When the counter reaches 0, the next edge performs the access and enters RESP.
  - RESP: resp_valid = 1, and resp_rdata and resp_err are held stable until resp_ready = 1 at a rising edge. On that handshake edge, go to IDLE with resp_valid = 0.
  - req_ready is 0 in RESP. A new request is never accepted in the same cycle as a response handshake.
- Latency: with the accept at edge E, resp_valid is high after edge E + WAIT_CYCLES + 1. For WAIT_CYCLES = 0, resp_valid is high after E + 1.
- Access step:
  - Happens exactly once per request, on the edge that enters RESP.
  - Stores update RAM on that edge only.
  - Loads read the latched address and register the result into resp_rdata on the same edge.
- Alignment:
  - Half requires addr[0] = 0. Word requires addr[1:0] = 00. size = 11 is always illegal.
  - A violation sets resp_err = 1 and resp_rdata = 0, and the RAM is not written.
- Little-endian byte order: word byte k lives at addr + k. Half uses bytes addr and addr + 1.
- Load extension:
  - Byte: bit 7 is replicated into [31:8] when req_unsigned = 0; zeros otherwise.
  - Half: same rule using bit 15.
  - Word: returned unmodified; req_unsigned is ignored.
- Stores write wdata[7:0], wdata[15:0] or wdata[31:0], depending on size. No other bytes change.
- Address wrap: none is needed, because aligned accesses never cross the top of the RAM.
- Request fields may change freely while req_ready = 0 and are ignored.
- If resp_ready is held at 0, resp_valid stays 1 indefinitely and outputs do not change.

Test Plan:
1. Reset with rst = 0 mid-WAIT of a store (word 0xDEADBEEF at 0x10). Then load word 0x10 → returns the prior contents, not 0xDEADBEEF. After reset, req_ready = 1 and resp_valid = 0.
2. WAIT_CYCLES = 2: store word 0x12345678 at 0x20, accepted at edge 0. resp_valid rises after edge 3 with resp_err = 0. Then:
   - Load byte 0x21, signed → 0x00000056.
   - Load half 0x22 → 0x00001234.
   - Load byte 0x23 → 0x00000012.
3. Store byte 0x80 at 0x30, then:
   - Signed byte load → 0xFFFFFF80.
   - Unsigned byte load → 0x00000080.
   - Store half 0xFFFF at 0x32, then word load at 0x30 → 0xFFFF0080 (0x31 previously 0).
4. Misaligned word load at 0x05, half store at 0x07, and size = 11 at 0x08 → each gives resp_err = 1 and resp_rdata = 0. Word load at 0x04 confirms the half store at 0x07 did not write.
5. Backpressure: hold resp_ready = 0 for 5 cycles after resp_valid rises → resp_valid and resp_rdata stay stable and req_ready = 0. Release resp_ready → resp_valid falls and req_ready = 1 on the next cycle.
6. WAIT_CYCLES = 0 build: back-to-back requests with resp_ready tied to 1 → each request completes in 2 cycles (accept, then response), and stores are visible to the very next load.
